// File: rtl/scr1_tcm_port_ctrl.sv
// scr1_tcm_port_ctrl: maps IMEM/DMEM req/ack/resp handshakes onto TCM dual-port RAM cycles.
module scr1_tcm_port_ctrl #(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 32'h00010000,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
    localparam int AW         = $clog2(SCR1_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   imem_req,
    input  logic [31:0]            imem_addr,
    output logic                   imem_ack,
    output logic [SCR1_WIDTH-1:0]  imem_rdata,
    output logic [1:0]             imem_resp,
    input  logic                   dmem_req,
    input  logic                   dmem_cmd,
    input  logic [1:0]             dmem_width,
    input  logic [31:0]            dmem_addr,
    input  logic [SCR1_WIDTH-1:0]  dmem_wdata,
    output logic                   dmem_ack,
    output logic [SCR1_WIDTH-1:0]  dmem_rdata,
    output logic [1:0]             dmem_resp,
    output logic                   rena,
    output logic [AW-3:0]          addra,
    input  logic [SCR1_WIDTH-1:0]  qa,
    output logic                   renb,
    output logic                   wenb,
    output logic [SCR1_NBYTES-1:0] webb,
    output logic [AW-3:0]          addrb,
    output logic [SCR1_WIDTH-1:0]  datab,
    input  logic [SCR1_WIDTH-1:0]  qb
);
    typedef enum logic {ST_IDLE, ST_RESP} state_t;
    localparam logic [1:0] RESP_IDLE  = 2'b00;
    localparam logic [1:0] RESP_OKAY  = 2'b01;
    localparam logic [1:0] RESP_ERROR = 2'b10;

    state_t i_state, i_next, d_state, d_next;
    logic i_err, d_err, d_wr, i_bad, d_bad;
    logic [1:0] d_off, d_width;
    logic [SCR1_NBYTES-1:0] be;
    logic [SCR1_WIDTH-1:0] d_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_state <= ST_IDLE;
            d_state <= ST_IDLE;
            i_err   <= 1'b0;
            d_err   <= 1'b0;
            d_wr    <= 1'b0;
            d_off   <= 2'b00;
            d_width <= 2'b00;
        end else begin
            i_state <= i_next;
            d_state <= d_next;
            if (imem_ack) i_err <= i_bad;
            if (dmem_ack) begin
                d_err   <= d_bad;
                d_wr    <= dmem_cmd;
                d_off   <= dmem_addr[1:0];
                d_width <= dmem_width;
            end
        end
    end

    always_comb begin
        i_next = imem_ack ? ST_RESP : ST_IDLE;
        d_next = dmem_ack ? ST_RESP : ST_IDLE;
    end

    // A port in RESP always issues its response this cycle, so a new request is accepted too.
    assign imem_ack = imem_req && !rst && (i_state == ST_IDLE || imem_resp != RESP_IDLE);
    assign dmem_ack = dmem_req && !rst && (d_state == ST_IDLE || dmem_resp != RESP_IDLE);

    assign i_bad = (|imem_addr[31:AW]) || (|imem_addr[1:0]);
    assign d_bad = (|dmem_addr[31:AW]) || dmem_width == 2'b11
                || (dmem_width == 2'b01 && dmem_addr[0])
                || (dmem_width == 2'b10 && |dmem_addr[1:0]);

    assign rena  = imem_ack && !i_bad;
    assign addra = rena ? imem_addr[AW-1:2] : '0;
    assign renb  = dmem_ack && !d_bad && !dmem_cmd;
    assign wenb  = dmem_ack && !d_bad && dmem_cmd;
    assign addrb = (renb || wenb) ? dmem_addr[AW-1:2] : '0;
    assign be    = dmem_width == 2'b00 ? SCR1_NBYTES'(1) : dmem_width == 2'b01 ? SCR1_NBYTES'(3) : '1;
    assign webb  = wenb ? be << dmem_addr[1:0] : '0;
    assign datab = wenb ? dmem_wdata << {dmem_addr[1:0], 3'b000} : '0;

    assign imem_resp  = i_state == ST_RESP ? (i_err ? RESP_ERROR : RESP_OKAY) : RESP_IDLE;
    assign dmem_resp  = d_state == ST_RESP ? (d_err ? RESP_ERROR : RESP_OKAY) : RESP_IDLE;
    assign imem_rdata = imem_resp == RESP_OKAY ? qa : '0;
    assign d_mask     = d_width == 2'b00 ? SCR1_WIDTH'(8'hFF) : d_width == 2'b01 ? SCR1_WIDTH'(16'hFFFF) : '1;
    assign dmem_rdata = (dmem_resp == RESP_OKAY && !d_wr) ? (qb >> {d_off, 3'b000}) & d_mask : '0;
endmodule

// File: tb/tb_scr1_tcm_port_ctrl.sv
// tb_scr1_tcm_port_ctrl: vector table plus reset corner sequences against a read-before-write RAM model.
module tb_scr1_tcm_port_ctrl;
    localparam logic [1:0] RI = 2'b00, RO = 2'b01, RE = 2'b10;

    logic clk = 1'b0, rst = 1'b1;
    logic imem_req, dmem_req, dmem_cmd, imem_ack, dmem_ack, rena, renb, wenb;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, imem_rdata, dmem_rdata, qa, qb, datab;
    logic [1:0] imem_resp, dmem_resp, dmem_width;
    logic [13:0] addra, addrb;
    logic [3:0] webb;
    logic [31:0] mem [0:16383];
    int errors = 0, checks = 0;

    typedef struct {
        logic ireq; logic [31:0] iaddr; logic dreq, dcmd; logic [1:0] dw; logic [31:0] daddr, dwdata;
        logic iack, rena; logic [13:0] addra; logic dack, renb, wenb; logic [3:0] webb;
        logic [13:0] addrb; logic [31:0] datab; logic [1:0] iresp; logic [31:0] irdata;
        logic [1:0] dresp; logic [31:0] drdata;
    } vec_t;
    vec_t v [22];

    scr1_tcm_port_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .rena(rena), .addra(addra), .qa(qa),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rena) qa <= mem[addra];
        if (renb) qb <= mem[addrb];
        if (wenb)
            for (int b = 0; b < 4; b++)
                if (webb[b]) mem[addrb][8*b +: 8] <= datab[8*b +: 8];
    end

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dcmd,
                         input logic [1:0] dw, input logic [31:0] daddr, input logic [31:0] dwdata);
        imem_req = ireq; imem_addr = iaddr; dmem_req = dreq; dmem_cmd = dcmd;
        dmem_width = dw; dmem_addr = daddr; dmem_wdata = dwdata;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
        qa = 32'h0; qb = 32'h0;
        // ireq iaddr dreq dcmd dw daddr dwdata | iack rena addra dack renb wenb webb addrb datab iresp irdata dresp drdata
        v[0]  = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RI,32'h0};
        v[1]  = '{1'b0,32'h0,1'b1,1'b1,2'd2,32'h100,32'hDEADBEEF, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b1,4'hF,14'h40,32'hDEADBEEF, RI,32'h0,RI,32'h0};
        v[2]  = '{1'b0,32'h0,1'b1,1'b0,2'd2,32'h100,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b1,1'b0,4'h0,14'h40,32'h0, RI,32'h0,RO,32'h0};
        v[3]  = '{1'b0,32'h0,1'b1,1'b1,2'd0,32'h103,32'hAB, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b1,4'h8,14'h40,32'hAB000000, RI,32'h0,RO,32'hDEADBEEF};
        v[4]  = '{1'b0,32'h0,1'b1,1'b0,2'd0,32'h103,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b1,1'b0,4'h0,14'h40,32'h0, RI,32'h0,RO,32'h0};
        v[5]  = '{1'b0,32'h0,1'b1,1'b0,2'd1,32'h101,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RO,32'hAB};
        v[6]  = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RE,32'h0};
        v[7]  = '{1'b1,32'h10000,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b1,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RI,32'h0};
        v[8]  = '{1'b1,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b1,1'b1,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RE,32'h0,RI,32'h0};
        v[9]  = '{1'b1,32'h4,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b1,1'b1,14'h1,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RO,32'h11111111,RI,32'h0};
        v[10] = '{1'b1,32'h8,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b1,1'b1,14'h2,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RO,32'h22222222,RI,32'h0};
        v[11] = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RO,32'h33333333,RI,32'h0};
        v[12] = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RI,32'h0};
        v[13] = '{1'b1,32'h0,1'b1,1'b1,2'd2,32'h0,32'hCAFEF00D, 1'b1,1'b1,14'h0,1'b1,1'b0,1'b1,4'hF,14'h0,32'hCAFEF00D, RI,32'h0,RI,32'h0};
        v[14] = '{1'b1,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b1,1'b1,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RO,32'h11111111,RO,32'h0};
        v[15] = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RO,32'hCAFEF00D,RI,32'h0};
        v[16] = '{1'b0,32'h0,1'b1,1'b0,2'd3,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RI,32'h0};
        v[17] = '{1'b0,32'h0,1'b1,1'b1,2'd2,32'h102,32'h12345678, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RE,32'h0};
        v[18] = '{1'b0,32'h0,1'b1,1'b1,2'd1,32'h102,32'hFFFF5678, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b1,4'hC,14'h40,32'h56780000, RI,32'h0,RE,32'h0};
        v[19] = '{1'b0,32'h0,1'b1,1'b0,2'd1,32'h102,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b1,1'b0,4'h0,14'h40,32'h0, RI,32'h0,RO,32'h0};
        v[20] = '{1'b0,32'h0,1'b1,1'b0,2'd2,32'h10100,32'h0, 1'b0,1'b0,14'h0,1'b1,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RO,32'h5678};
        v[21] = '{1'b0,32'h0,1'b0,1'b0,2'd0,32'h0,32'h0, 1'b0,1'b0,14'h0,1'b0,1'b0,1'b0,4'h0,14'h0,32'h0, RI,32'h0,RE,32'h0};

        drive(1'b1, 32'h0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
        #2;
        check("rst_iack", 0, 32'(imem_ack), 32'h0);
        check("rst_rena", 0, 32'(rena), 32'h0);
        check("rst_dack", 0, 32'(dmem_ack), 32'h0);
        check("rst_renb", 0, 32'(renb), 32'h0);
        check("rst_iresp", 0, 32'(imem_resp), 32'(RI));
        check("rst_dresp", 0, 32'(dmem_resp), 32'(RI));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            drive(v[i].ireq, v[i].iaddr, v[i].dreq, v[i].dcmd, v[i].dw, v[i].daddr, v[i].dwdata);
            @(negedge clk);
            check("iack", i, 32'(imem_ack), 32'(v[i].iack));
            check("rena", i, 32'(rena), 32'(v[i].rena));
            check("addra", i, 32'(addra), 32'(v[i].addra));
            check("dack", i, 32'(dmem_ack), 32'(v[i].dack));
            check("renb", i, 32'(renb), 32'(v[i].renb));
            check("wenb", i, 32'(wenb), 32'(v[i].wenb));
            check("webb", i, 32'(webb), 32'(v[i].webb));
            check("addrb", i, 32'(addrb), 32'(v[i].addrb));
            check("datab", i, datab, v[i].datab);
            check("iresp", i, 32'(imem_resp), 32'(v[i].iresp));
            check("irdata", i, imem_rdata, v[i].irdata);
            check("dresp", i, 32'(dmem_resp), 32'(v[i].dresp));
            check("drdata", i, dmem_rdata, v[i].drdata);
        end

        // Reset hits between accept and the response cycle.
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        @(negedge clk);
        check("seqA_dack", 0, 32'(dmem_ack), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("seqA_dack_rst", 0, 32'(dmem_ack), 32'h0);
        check("seqA_renb_rst", 0, 32'(renb), 32'h0);
        @(posedge clk); #1;
        check("seqA_dresp", 0, 32'(dmem_resp), 32'(RI));
        check("seqA_drdata", 0, dmem_rdata, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            check("seqA_after", k, 32'(dmem_resp), 32'(RI));
        end

        // Reset asserted during the response cycle clears it at once.
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        check("seqB_dresp", 0, 32'(dmem_resp), 32'(RO));
        check("seqB_drdata", 0, dmem_rdata, 32'h5678BEEF);
        rst = 1'b1;
        #1;
        check("seqB_dresp_rst", 0, 32'(dmem_resp), 32'(RI));
        check("seqB_drdata_rst", 0, dmem_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("seqB_after", 0, 32'(dmem_resp), 32'(RI));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
